// File: rtl/ofdm_cp_inserter.sv
// Transmit-side cyclic-prefix inserter: ping-pong buffers whole OFDM symbols and replays
// each one as its last L samples followed by all NFFT samples.
module ofdm_cp_inserter #(
    parameter int unsigned DW     = 16,
    parameter int unsigned NFFT   = 64,
    parameter int unsigned CP_MAX = 16
) (
    input  logic                             i_clk,
    input  logic                             i_reset,
    input  logic                             i_di_en,
    input  logic [DW-1:0]                    i_di_re,
    input  logic [DW-1:0]                    i_di_im,
    input  logic [$clog2(CP_MAX + 1)-1:0]    i_cp_len,
    output logic                             o_do_en,
    output logic [DW-1:0]                    o_do_re,
    output logic [DW-1:0]                    o_do_im,
    output logic                             o_do_sop,
    output logic                             o_do_cp,
    output logic                             o_ovf,
    output logic                             o_busy
);

    localparam int unsigned AW = $clog2(NFFT);
    localparam int unsigned LW = $clog2(CP_MAX + 1);
    localparam logic [AW-1:0] LastAddr = AW'(NFFT - 1);
    localparam logic [LW-1:0] LMax     = LW'(CP_MAX);

    typedef enum logic [1:0] {StIdle, StCp, StBody} state_e;

    logic [2*DW-1:0] r_mem [2*NFFT];

    logic            r_wr_bank;
    logic [AW-1:0]   r_wr_addr;
    logic [1:0]      r_full;

    state_e          r_state, w_state_d;
    logic            r_rd_bank;
    logic [AW-1:0]   r_rd_addr, w_rd_addr_d;

    logic            w_rd_valid, w_rd_sop, w_rd_cp, w_rd_done;
    logic [AW-1:0]   w_rd_addr;
    logic [2*DW-1:0] w_rd_data;
    logic [LW-1:0]   w_l;
    logic [AW-1:0]   w_cp_addr;

    logic            w_wr_accept, w_wr_last;
    logic [1:0]      w_set, w_clr;

    logic            r_do_en, r_do_sop, r_do_cp;
    logic [DW-1:0]   r_do_re, r_do_im;

    assign w_l       = (i_cp_len > LMax) ? LMax : i_cp_len;
    assign w_cp_addr = AW'(NFFT - 32'(w_l));

    // A bank freed by the final body read may be written in that same cycle.
    assign w_clr       = w_rd_done ? (r_rd_bank ? 2'b10 : 2'b01) : 2'b00;
    assign w_wr_accept = i_di_en & (~r_full[r_wr_bank] | w_clr[r_wr_bank]);
    assign w_wr_last   = w_wr_accept & (r_wr_addr == LastAddr);
    assign w_set       = w_wr_last ? (r_wr_bank ? 2'b10 : 2'b01) : 2'b00;

    assign w_rd_data = r_mem[{r_rd_bank, w_rd_addr}];

    always_comb begin
        w_state_d   = r_state;
        w_rd_addr_d = r_rd_addr;
        w_rd_addr   = r_rd_addr;
        w_rd_valid  = 1'b0;
        w_rd_sop    = 1'b0;
        w_rd_cp     = 1'b0;
        w_rd_done   = 1'b0;
        unique case (r_state)
            StIdle: begin
                // First read is issued in the same cycle the full flag is seen.
                if (r_full[r_rd_bank]) begin
                    w_rd_valid = 1'b1;
                    w_rd_sop   = 1'b1;
                    if (w_l != '0) begin
                        w_rd_cp   = 1'b1;
                        w_rd_addr = w_cp_addr;
                        if (w_cp_addr == LastAddr) begin
                            w_state_d   = StBody;
                            w_rd_addr_d = '0;
                        end else begin
                            w_state_d   = StCp;
                            w_rd_addr_d = w_cp_addr + AW'(1);
                        end
                    end else begin
                        w_rd_addr   = '0;
                        w_state_d   = StBody;
                        w_rd_addr_d = AW'(1);
                    end
                end
            end
            StCp: begin
                w_rd_valid = 1'b1;
                w_rd_cp    = 1'b1;
                if (r_rd_addr == LastAddr) begin
                    w_state_d   = StBody;
                    w_rd_addr_d = '0;
                end else begin
                    w_rd_addr_d = r_rd_addr + AW'(1);
                end
            end
            StBody: begin
                w_rd_valid = 1'b1;
                if (r_rd_addr == LastAddr) begin
                    w_rd_done   = 1'b1;
                    w_state_d   = StIdle;
                    w_rd_addr_d = '0;
                end else begin
                    w_rd_addr_d = r_rd_addr + AW'(1);
                end
            end
            default: begin
                w_state_d   = StIdle;
                w_rd_addr_d = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (w_wr_accept && i_reset) begin
            r_mem[{r_wr_bank, r_wr_addr}] <= {i_di_re, i_di_im};
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_wr_bank <= 1'b0;
            r_wr_addr <= '0;
            r_full    <= '0;
            r_state   <= StIdle;
            r_rd_bank <= 1'b0;
            r_rd_addr <= '0;
            r_do_en   <= 1'b0;
            r_do_sop  <= 1'b0;
            r_do_cp   <= 1'b0;
            r_do_re   <= '0;
            r_do_im   <= '0;
        end else begin
            if (w_wr_accept) begin
                r_wr_addr <= r_wr_addr + AW'(1);
                if (w_wr_last) begin
                    r_wr_bank <= ~r_wr_bank;
                end
            end
            r_full    <= (r_full & ~w_clr) | w_set;
            r_state   <= w_state_d;
            r_rd_addr <= w_rd_addr_d;
            if (w_rd_done) begin
                r_rd_bank <= ~r_rd_bank;
            end
            r_do_en  <= w_rd_valid;
            r_do_sop <= w_rd_sop;
            r_do_cp  <= w_rd_cp;
            r_do_re  <= w_rd_valid ? w_rd_data[2*DW-1:DW] : '0;
            r_do_im  <= w_rd_valid ? w_rd_data[DW-1:0] : '0;
        end
    end

    assign o_do_en  = r_do_en;
    assign o_do_re  = r_do_re;
    assign o_do_im  = r_do_im;
    assign o_do_sop = r_do_sop;
    assign o_do_cp  = r_do_cp;
    assign o_ovf    = i_di_en & ~w_wr_accept;
    assign o_busy   = (|r_full) | (r_state != StIdle);

endmodule

// File: tb/tb_ofdm_cp_inserter.sv
// Bench for ofdm_cp_inserter: stimulus tables replayed cycle by cycle against an
// expected-output schedule computed from symbol completion times.
module tb_ofdm_cp_inserter;

    localparam int DW     = 16;
    localparam int NFFT   = 64;
    localparam int CP_MAX = 16;
    localparam int LW     = $clog2(CP_MAX + 1);
    localparam int MAXC   = 1024;
    localparam int VW     = 2 * DW + 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          di_en;
    logic [DW-1:0] di_re, di_im;
    logic [LW-1:0] cp_len;
    logic          do_en, do_sop, do_cp, ovf, busy;
    logic [DW-1:0] do_re, do_im;

    always #5 clk = ~clk;

    ofdm_cp_inserter #(.DW(DW), .NFFT(NFFT), .CP_MAX(CP_MAX)) dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .i_di_en (di_en),
        .i_di_re (di_re),
        .i_di_im (di_im),
        .i_cp_len(cp_len),
        .o_do_en (do_en),
        .o_do_re (do_re),
        .o_do_im (do_im),
        .o_do_sop(do_sop),
        .o_do_cp (do_cp),
        .o_ovf   (ovf),
        .o_busy  (busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    bit            st_en [MAXC];
    logic [DW-1:0] st_re [MAXC];
    logic [DW-1:0] st_im [MAXC];
    logic [LW-1:0] st_cp [MAXC];
    logic [VW-1:0] ex_vec[MAXC];
    int            ex_cnt;

    function automatic void clear_stim(input int cp);
        for (int i = 0; i < MAXC; i++) begin
            st_en[i] = 1'b0;
            st_re[i] = '0;
            st_im[i] = '0;
            st_cp[i] = LW'(cp);
        end
    endfunction

    function automatic void put_symbol(input int start, input bit ramp);
        for (int k = 0; k < NFFT; k++) begin
            st_en[start+k] = 1'b1;
            st_re[start+k] = ramp ? DW'(k) : DW'($urandom);
            st_im[start+k] = ramp ? DW'(-k) : DW'($urandom);
        end
    endfunction

    // Expected vector layout: {busy, ovf, do_en, do_sop, do_cp, do_re, do_im}.
    // A symbol completed at cycle t starts output at max(t+2, previous end+1), uses the
    // cp_len seen the cycle before, and frees its bank on its last read cycle.
    task automatic build_model(input int n, input int reset_at);
        logic [2*DW-1:0] bank[2][NFFT];
        int wb, wa, last_out;
        int free_at[2];
        wb = 0; wa = 0; last_out = -1;
        free_at[0] = 0; free_at[1] = 0;
        for (int c = 0; c < n; c++) ex_vec[c] = '0;
        for (int c = 0; c < n; c++) begin
            if (reset_at >= 0 && c > reset_at) break;
            if (st_en[c]) begin
                if (c >= free_at[wb]) begin
                    bank[wb][wa] = {st_re[c], st_im[c]};
                    if (wa == NFFT - 1) begin
                        int s, l, idx;
                        s   = (c + 2 > last_out + 1) ? c + 2 : last_out + 1;
                        idx = (s - 1 < n) ? s - 1 : n - 1;
                        l   = int'(st_cp[idx]);
                        if (l > CP_MAX) l = CP_MAX;
                        for (int i = 0; i < NFFT + l; i++) begin
                            int oc, a;
                            oc = s + i;
                            a  = (i < l) ? NFFT - l + i : i - l;
                            if (oc < n) begin
                                ex_vec[oc][2*DW+2]   = 1'b1;
                                ex_vec[oc][2*DW+1]   = (i == 0);
                                ex_vec[oc][2*DW]     = (i < l);
                                ex_vec[oc][2*DW-1:0] = bank[wb][a];
                            end
                        end
                        for (int b = c + 1; b <= s + NFFT + l - 2; b++) begin
                            if (b < n) ex_vec[b][2*DW+4] = 1'b1;
                        end
                        free_at[wb] = s + NFFT + l - 2;
                        last_out    = s + NFFT + l - 1;
                        wa = 0;
                        wb ^= 1;
                    end else begin
                        wa++;
                    end
                end else begin
                    ex_vec[c][2*DW+3] = 1'b1;
                end
            end
        end
        if (reset_at >= 0) begin
            for (int c = reset_at + 1; c < n; c++) ex_vec[c] = '0;
        end
        ex_cnt = 0;
        for (int c = 0; c < n; c++) if (ex_vec[c][2*DW+2]) ex_cnt++;
    endtask

    task automatic run_stim(input string name, input int n, input bit do_reset,
                            input int reset_at);
        logic [VW-1:0] vec;
        int obs;
        build_model(n, reset_at);
        if (do_reset) begin
            @(negedge clk);
            rst_n = 1'b0;
            di_en = 1'b0;
        end
        obs = 0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            rst_n  = (c == reset_at) ? 1'b0 : 1'b1;
            di_en  = st_en[c];
            di_re  = st_re[c];
            di_im  = st_im[c];
            cp_len = st_cp[c];
            #1;
            vec = {busy, ovf, do_en, do_sop, do_cp, do_re, do_im};
            n_tests++;
            if (vec !== ex_vec[c]) begin
                n_fail++;
                $display("FAIL %s cycle %0d: got {busy,ovf,en,sop,cp,re,im}=%b %b %b %b %b %h %h, expected %b %b %b %b %b %h %h",
                         name, c, vec[2*DW+4], vec[2*DW+3], vec[2*DW+2], vec[2*DW+1],
                         vec[2*DW], vec[2*DW-1:DW], vec[DW-1:0],
                         ex_vec[c][2*DW+4], ex_vec[c][2*DW+3], ex_vec[c][2*DW+2],
                         ex_vec[c][2*DW+1], ex_vec[c][2*DW], ex_vec[c][2*DW-1:DW],
                         ex_vec[c][DW-1:0]);
            end
            if (do_en === 1'b1) obs++;
        end
        di_en = 1'b0;
        rst_n = 1'b1;
        n_tests++;
        if (obs != ex_cnt) begin
            n_fail++;
            $display("FAIL %s do_en count: got %0d, expected %0d", name, obs, ex_cnt);
        end
    endtask

    task automatic test_reset();
        logic [VW-1:0] vec;
        rst_n  = 1'b0;
        di_en  = 1'b0;
        di_re  = '0;
        di_im  = '0;
        cp_len = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            vec = {busy, ovf, do_en, do_sop, do_cp, do_re, do_im};
            if (i > 0) begin
                n_tests++;
                if (vec !== '0) begin
                    n_fail++;
                    $display("FAIL reset_state: got %h, expected 0", vec);
                end
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single_cp16();
        clear_stim(16);
        put_symbol(0, 1'b1);
        run_stim("single_cp16", 200, 1'b1, -1);
    endtask

    task automatic test_no_cp();
        clear_stim(0);
        put_symbol(0, 1'b1);
        run_stim("no_cp", 160, 1'b1, -1);
    endtask

    task automatic test_gap();
        clear_stim(16);
        put_symbol(0, 1'b0);
        put_symbol(80, 1'b0);
        run_stim("gap", 260, 1'b1, -1);
    endtask

    task automatic test_back_to_back();
        clear_stim(16);
        put_symbol(0, 1'b0);
        put_symbol(64, 1'b0);
        put_symbol(128, 1'b0);
        run_stim("back_to_back", 300, 1'b1, -1);
    endtask

    task automatic test_clamp();
        clear_stim(31);
        for (int c = 100; c < MAXC; c++) st_cp[c] = LW'(4);
        put_symbol(0, 1'b0);
        put_symbol(150, 1'b0);
        run_stim("clamp", 320, 1'b1, -1);
    endtask

    task automatic test_random();
        int cp;
        clear_stim(0);
        cp = 0;
        for (int c = 0; c < 900; c++) begin
            if ($urandom_range(0, 39) == 0) cp = $urandom_range(0, 31);
            st_cp[c] = LW'(cp);
            if (c < 700) begin
                st_en[c] = ($urandom_range(0, 99) < 85);
                st_re[c] = DW'($urandom);
                st_im[c] = DW'($urandom);
            end
        end
        run_stim("random", 900, 1'b1, -1);
    endtask

    task automatic test_reset_mid();
        clear_stim(16);
        put_symbol(0, 1'b1);
        run_stim("reset_mid", 110, 1'b1, 70);
        clear_stim(16);
        put_symbol(0, 1'b0);
        run_stim("after_reset", 200, 1'b0, -1);
    endtask

    initial begin
        test_reset();
        test_single_cp16();
        test_no_cp();
        test_gap();
        test_back_to_back();
        test_clamp();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ofdm_cp_inserter.md
Name: ofdm_cp_inserter

Overview:
- Parametrised transmit-side cyclic-prefix inserter.
- Sits between the IFFT output (di_en/di_re/di_im style) and the channel/receiver FFT input.
- Buffers complete OFDM symbols in a ping-pong RAM and emits each one as the last L samples followed by all NFFT samples.
- L is selectable at run time per symbol, up to CP_MAX; L=0 gives transparent re-timing.

Parameters:
- DW, 16, width of each of the re/im sample components (signed two's complement).
- NFFT, 64, samples per OFDM symbol; power of 2, ≥8.
- CP_MAX, 16, maximum prefix length; must be < NFFT.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset.
- di_en  in  1  input sample valid, one sample per cycle when high.
- di_re  in  DW  input real part.
- di_im  in  DW  input imaginary part.
- cp_len  in  clog2(CP_MAX+1)  requested prefix length; sampled at symbol start.
- do_en  out  1  output sample valid.
- do_re  out  DW  output real part.
- do_im  out  DW  output imaginary part.
- do_sop  out  1  high on the first output sample of each symbol (first prefix sample, or sample 0 if L=0).
- do_cp  out  1  high while prefix samples are being output.
- ovf  out  1  one-cycle pulse per dropped input sample.
- busy  out  1  high when any bank is full or being read.

Behaviour:
- Reset (reset==0 at a rising edge):
  - All outputs are 0 from the next cycle.
  - Both bank-full flags clear; write/read counters go to 0; read FSM goes to IDLE.
  - Any partial or buffered symbol is discarded. Applies mid-symbol too, with no residual do_en.
- Storage: two banks A/B, each NFFT x 2*DW. Write pointer starts at bank A, address 0.
- Write side:
  - Each di_en cycle writes {di_re,di_im} to the current write bank at wr_addr, then wr_addr increments.
  - The write at wr_addr==NFFT-1 sets that bank's full flag, wraps wr_addr to 0 and toggles the write bank.
  - If di_en is high while the current write bank is full (still unread or being read), the sample is dropped, ovf pulses that cycle and wr_addr holds.
  - Gaps in di_en are allowed anywhere.
- Read FSM states:
  - IDLE: waits for the read bank's full flag.
  - CP: reads addresses NFFT-L .. NFFT-1.
  - BODY: reads addresses 0 .. NFFT-1.
- Start of symbol:
  - Leaving IDLE, or back-to-back from the end of BODY, latches L = min(cp_len, CP_MAX).
  - Next state is CP if L>0, else BODY.
  - cp_len changes mid-symbol have no effect.
- RAM read is registered, so do_en/do_re/do_im/do_sop/do_cp appear 1 cycle after the read address is issued.
- Latency: the last input write of a symbol at cycle T puts the first output (do_en=1, do_sop=1) at T+2, provided the reader is IDLE.
- End of symbol:
  - On the BODY read of address NFFT-1, the read bank's full flag clears in that same cycle and the read bank toggles.
  - If the other bank is already full, the next cycle starts the next symbol's CP/BODY with no do_en gap. Otherwise go to IDLE.
- Each symbol produces exactly NFFT+L consecutive do_en cycles. do_cp is high for exactly the first L of them.
- Simultaneous events:
  - A write completing a bank and a read freeing the other bank in the same cycle are both honoured.
  - A write to a bank in the same cycle its full flag clears is permitted and accepted, with no ovf.
- When do_en=0, do_re/do_im hold 0.
- No arithmetic is done on samples; data passes bit-exact.

Test Plan:
- NFFT=64, CP_MAX=16, cp_len=16; one symbol di_re=k, di_im=-k, k=0..63 on cycles 0..63 -> do_en high cycles 65..144. do_re=48..63 then 0..63; do_im is the negation. do_sop only at 65; do_cp high 65..80; ovf never.
- cp_len=0, same ramp -> 64 do_en cycles 65..128, outputs equal inputs, do_cp never high, do_sop at 65.
- Two symbols with a 16-cycle di_en gap between them -> 160 contiguous do_en cycles. do_sop at sample 0 and at sample 80. Second symbol's prefix = its samples 48..63.
- Continuous di_en for 3 symbols (192 cycles), cp_len=16 -> symbols 1 and 2 output bit-exact and back-to-back. ovf first pulses at cycle 128 and drops samples until bank A frees. No corruption of symbol 1.
- CP_MAX=16, cp_len=31 -> L clamped to 16, 80 outputs per symbol. Change cp_len to 4 mid-symbol -> current symbol unaffected, next symbol 68 outputs.
- reset=0 for one cycle during the CP phase of symbol 1 -> do_en=0 on the following cycle, busy=0, no further outputs. A fresh symbol afterwards produces the normal 80-sample response with latency T+2.
